pipe_stage_fifo: RTL
====================

# pipe_stage_fifo

Parametrised pipeline stage buffer. It is the next-generation replacement for the fixed dreg/ereg/mreg/wreg stage registers. Each stage register becomes a DEPTH-entry FIFO of DATA_W-bit stage records (fetch_data_t, decode_data_t, …) with a valid/ready handshake on both sides, plus the legacy stall/flush controls driven by the hazard unit. Sits between two adjacent pipeline stages; DEPTH=1 with READY_REG=0 reproduces a classic stall/flush stage register.

## Interface
Parameters:
- DATA_W, default 32: width of one stage record in bits; must be ≥1.
- DEPTH, default 2: number of entries; must be ≥1.
- READY_REG, default 0:
  - 0: in_ready may depend combinationally on out_ready (full-throughput pass).
  - 1: in_ready is a function of occupancy only.
- CNT_W, default $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: producer has a record.
- in_data, in, DATA_W: producer record.
- in_ready, out, 1: stage accepts a record this cycle.
- out_valid, out, 1: head entry is valid.
- out_data, out, DATA_W: head entry.
- out_ready, in, 1: consumer accepts the head this cycle.
- stall, in, 1: hazard stall; blocks the pop and the push side.
- flush, in, 1: hazard flush; discards all entries.
- count, out, CNT_W: current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries, with read pointer rd_ptr, write pointer wr_ptr and occupancy count.
  - Pointers wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
- Handshake terms:
  - pop = out_valid & out_ready & !stall.
  - push = in_valid & in_ready.
- out_valid = (count != 0).
- out_data = mem[rd_ptr]. It is combinational from registered state, with no input-to-output combinational path.
- in_ready:
  - Always 0 while stall=1.
  - Otherwise, for READY_REG=0: (count < DEPTH) | out_ready.
  - Otherwise, for READY_REG=1: (count < DEPTH).
- Update rules, applied in priority order at each edge:
  1. reset: rd_ptr=wr_ptr=count=0; all entries cleared to 0.
  2. flush: rd_ptr=wr_ptr=count=0. Entry contents are don't-care. A push in the same cycle is discarded.
  3. Otherwise:
     - push writes in_data to mem[wr_ptr] and advances wr_ptr.
     - pop advances rd_ptr.
     - count += push - pop.
- Simultaneous push and pop:
  - When full and READY_REG=0, both occur and count stays at DEPTH. The new record occupies the slot freed by the head.
  - When empty, push and pop cannot both occur because out_valid=0. A record never bypasses storage.
- Overflow is impossible by construction: push requires in_ready.
- Underflow is impossible by construction: pop requires out_valid.
- Deasserting in_valid when in_ready=0 is permitted; no protocol error is raised.

## Timing
- Reset values: count=0, out_valid=0, out_data=0.
  - in_ready after reset: 1 unless stall=1.
- Latency: a record pushed at edge N is visible on out_data/out_valid after edge N (cycle N+1). This is one-cycle latency, no fall-through.
- Throughput: one record per cycle sustained for any DEPTH when out_ready=1 and stall=0.
  - With READY_REG=1 and DEPTH=1, throughput is one record per 2 cycles.
- Flush: out_valid=0 in the cycle after the flush edge. in_ready depends on stall.
- Reset asserted mid-stream drops all entries at that edge. Behaviour matches flush, plus the storage is zeroed.
- count is a registered value and reflects the state after the last edge.

## Test plan
- **Reset and basic push.** DATA_W=32, DEPTH=2.
  - Stimulus: hold reset 2 cycles; then push 0x11111111 with out_ready=0.
  - Required: after reset, count=0 and out_valid=0. Next cycle, out_valid=1, out_data=0x11111111, count=1.
- **Fill to full, then drain.** DEPTH=2, READY_REG=1, out_ready=0.
  - Stimulus: push A, B; attempt C; then set out_ready=1 with in_valid=0.
  - Required: in_ready=0 once count=2, and C is not accepted. Drain emits A then B, and count goes 2→1→0.
- **Full-throughput pass at DEPTH=1.** READY_REG=0.
  - Stimulus: in_valid=1 and out_ready=1 continuously with data 1,2,3,…
  - Required: out_data sequence is 1,2,3… with one per cycle. count stays 1.
- **Wrap-around at non-power-of-2 DEPTH.** DEPTH=3.
  - Stimulus: stream 10 records, with out_ready toggling 1,0,1,0…
  - Required: output order is exactly 0..9 with no loss or duplication. Pointers wrap correctly.
- **Stall behaviour.** DEPTH=2, holding X.
  - Stimulus: assert stall=1 for 3 cycles with out_ready=1 and in_valid=1 (Y).
  - Required: in_ready=0 throughout the stall, out_data stays X, count stays 1. After stall drops, X pops and then Y is accepted.
- **Flush with simultaneous push.** count=2.
  - Stimulus: assert flush=1 with in_valid=1 and data 0xDEAD.
  - Required: next cycle, count=0 and out_valid=0. 0xDEAD never appears on out_data.

Source files
------------

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: one pipeline stage buffer. It holds DEPTH records of
// DATA_W bits in a circular FIFO and uses a valid/ready handshake on both
// sides. The hazard unit also drives two controls:
// - stall blocks both push and pop.
// - flush discards every entry.
// With DEPTH=1 and READY_REG=0 the block acts as a classic stall/flush
// stage register.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears pointers, count and storage
//   in_valid   producer has a record
//   in_data    producer record
//   in_ready   stage accepts a record this cycle
//   out_valid  head entry is valid
//   out_data   head entry
//   out_ready  consumer accepts the head this cycle
//   stall      hazard stall; no push and no pop while asserted
//   flush      hazard flush; empties the buffer and drops a same-cycle push
//   count      registered occupancy, 0..DEPTH
module pipe_stage_fifo #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned READY_REG = 0,
    parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              stall,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Storage is rounded up to a power of two so that any pointer value
    // indexes a real entry. Only the first DEPTH entries are ever used.
    localparam int unsigned MEM_N = 1 << PTR_W;

    logic [DATA_W-1:0] mem [MEM_N];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              full;
    logic              push;
    logic              pop;

    // Advance a pointer and wrap it at DEPTH-1. DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready & ~stall;
    assign push      = in_valid & in_ready;

    // Ready logic. With READY_REG=0 a full buffer still accepts a record
    // when the head leaves in the same cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!stall) begin
            if (READY_REG != 0) begin
                in_ready = ~full;
            end else begin
                in_ready = ~full | out_ready;
            end
        end
    end

    // State update. Priority order: reset, then flush, then push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(MEM_N); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
